// File: rtl/sdram_init_refresh_ctrl_if.sv
// SDRAM command bus plus the refresh request/acknowledge handshake
// shared between the init/refresh sequencer and the access FSM side.
interface sdram_init_refresh_ctrl_if;
  logic        cs_n;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic [12:0] sd_addr;
  logic [1:0]  sd_ba;
  logic        cmd_own;
  logic        init_done;
  logic        ref_req;
  logic        ref_ack;
  logic        ref_err;

  modport master (
    output cs_n, ras_n, cas_n, we_n, sd_addr, sd_ba,
    output cmd_own, init_done, ref_req, ref_err,
    input  ref_ack
  );

  modport slave (
    input  cs_n, ras_n, cas_n, we_n, sd_addr, sd_ba,
    input  cmd_own, init_done, ref_req, ref_err,
    output ref_ack
  );
endinterface

// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM power-up sequencer and periodic AUTO REFRESH scheduler; owns the
// command bus during init and refresh, hands it to the access FSM otherwise.
module sdram_init_refresh_ctrl #(
  parameter int          INIT_CYCLES  = 5000,
  parameter int          TRP          = 2,
  parameter int          TRFC         = 4,
  parameter int          TMRD         = 2,
  parameter int          REF_INTERVAL = 780,
  parameter logic [12:0] MODE_VAL     = 13'h0033
) (
  input logic                       clk,
  input logic                       reset_n,
  sdram_init_refresh_ctrl_if.master bus
);

  localparam int MAX_AB   = (INIT_CYCLES > TRP) ? INIT_CYCLES : TRP;
  localparam int MAX_CD   = (TRFC > TMRD) ? TRFC : TMRD;
  localparam int MAX_WAIT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam int TMR_W    = $clog2(REF_INTERVAL + 1);

  localparam logic [3:0] CMD_INHIBIT = 4'b1111;
  localparam logic [3:0] CMD_NOP     = 4'b0111;
  localparam logic [3:0] CMD_PRE     = 4'b0010;
  localparam logic [3:0] CMD_REF     = 4'b0001;
  localparam logic [3:0] CMD_MRS     = 4'b0000;

  typedef enum logic [3:0] {
    WAIT, I_PRE, I_TRP, I_REF1, I_RFC1, I_REF2, I_RFC2, I_MRS, I_MRD,
    IDLE, R_PRE, R_TRP, R_REF, R_RFC
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   wait_len;
  logic               wait_last;
  logic [TMR_W-1:0]   timer;
  logic               timer_run;
  logic               wrap;
  logic               dec;
  logic [1:0]         backlog;
  logic [1:0]         backlog_d;
  logic [3:0]         cmd_d;
  logic [12:0]        addr_d;
  logic [3:0]         cmd_q;
  logic [12:0]        addr_q;
  logic [1:0]         ba_q;
  logic               own_q;
  logic               done_q;
  logic               req_q;
  logic               err_q;

  always_comb begin
    wait_len = CNT_W'(1);
    case (state)
      WAIT:                   wait_len = CNT_W'(INIT_CYCLES);
      I_TRP, R_TRP:           wait_len = CNT_W'(TRP);
      I_RFC1, I_RFC2, R_RFC:  wait_len = CNT_W'(TRFC);
      I_MRD:                  wait_len = CNT_W'(TMRD);
      default:                wait_len = CNT_W'(1);
    endcase
  end

  assign wait_last = (wait_cnt == wait_len - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= WAIT;
    end else begin
      state <= next_state;
    end
  end

  // Handshake uses the registered ref_req, i.e. what the access FSM actually saw.
  always_comb begin
    next_state = state;
    case (state)
      WAIT:    if (wait_last) next_state = I_PRE;
      I_PRE:   next_state = I_TRP;
      I_TRP:   if (wait_last) next_state = I_REF1;
      I_REF1:  next_state = I_RFC1;
      I_RFC1:  if (wait_last) next_state = I_REF2;
      I_REF2:  next_state = I_RFC2;
      I_RFC2:  if (wait_last) next_state = I_MRS;
      I_MRS:   next_state = I_MRD;
      I_MRD:   if (wait_last) next_state = IDLE;
      IDLE:    if (req_q && bus.ref_ack) next_state = R_PRE;
      R_PRE:   next_state = R_TRP;
      R_TRP:   if (wait_last) next_state = R_REF;
      R_REF:   next_state = R_RFC;
      R_RFC:   if (wait_last) next_state = IDLE;
      default: next_state = WAIT;
    endcase
  end

  // Reset counts as entry into WAIT, so the counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (next_state != state || state == IDLE) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timer_run = (state inside {IDLE, R_PRE, R_TRP, R_REF, R_RFC});
  assign wrap      = timer_run && (timer == TMR_W'(REF_INTERVAL - 1));
  assign dec       = (state == R_REF);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (timer_run) begin
      timer <= wrap ? '0 : timer + TMR_W'(1);
    end
  end

  always_comb begin
    backlog_d = backlog;
    if (wrap && !dec) begin
      if (backlog != 2'd3) backlog_d = backlog + 2'd1;
    end else if (dec && !wrap) begin
      if (backlog != 2'd0) backlog_d = backlog - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      backlog <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      backlog <= backlog_d;
      err_q   <= err_q | (wrap && backlog == 2'd3);
    end
  end

  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = 13'd0;
    case (state)
      I_PRE, R_PRE: begin
        cmd_d  = CMD_PRE;
        addr_d = 13'h0400;
      end
      I_REF1, I_REF2, R_REF: cmd_d = CMD_REF;
      I_MRS: begin
        cmd_d  = CMD_MRS;
        addr_d = MODE_VAL;
      end
      default: begin
        cmd_d  = CMD_NOP;
        addr_d = 13'd0;
      end
    endcase
  end

  // Every bus-visible output is one register stage behind the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_q  <= CMD_INHIBIT;
      addr_q <= 13'd0;
      ba_q   <= 2'd0;
      own_q  <= 1'b1;
      done_q <= 1'b0;
      req_q  <= 1'b0;
    end else begin
      cmd_q  <= cmd_d;
      addr_q <= addr_d;
      ba_q   <= 2'd0;
      own_q  <= (state != IDLE);
      done_q <= done_q | (state == IDLE);
      req_q  <= (state == IDLE) && (backlog != 2'd0);
    end
  end

  assign bus.cs_n      = cmd_q[3];
  assign bus.ras_n     = cmd_q[2];
  assign bus.cas_n     = cmd_q[1];
  assign bus.we_n      = cmd_q[0];
  assign bus.sd_addr   = addr_q;
  assign bus.sd_ba     = ba_q;
  assign bus.cmd_own   = own_q;
  assign bus.init_done = done_q;
  assign bus.ref_req   = req_q;
  assign bus.ref_err   = err_q;

endmodule

// File: tb/tb_sdram_init_refresh_ctrl.sv
// Directed bench for the SDRAM init/refresh sequencer: init timing, refresh
// handshake, backlog/overflow and reset recovery, plus a short-parameter instance.
module tb_sdram_init_refresh_ctrl;

  localparam logic [3:0] CMD_INHIBIT = 4'b1111;
  localparam logic [3:0] CMD_NOP     = 4'b0111;
  localparam logic [3:0] CMD_PRE     = 4'b0010;
  localparam logic [3:0] CMD_REF     = 4'b0001;
  localparam logic [3:0] CMD_MRS     = 4'b0000;
  localparam int SMALL_DONE = 10 + 4 + 1 + 2 * 1 + 1;

  logic clk = 1'b0;
  logic reset_n;
  logic reset2_n;
  int   cyc;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  sdram_init_refresh_ctrl_if bus ();
  sdram_init_refresh_ctrl_if bus2 ();

  sdram_init_refresh_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  sdram_init_refresh_ctrl #(
    .INIT_CYCLES (10),
    .TRP         (1),
    .TRFC        (1),
    .TMRD        (1)
  ) dut_small (
    .clk     (clk),
    .reset_n (reset2_n),
    .bus     (bus2)
  );

  function automatic logic [22:0] obs();
    return {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n, bus.sd_addr, bus.sd_ba,
            bus.cmd_own, bus.init_done, bus.ref_req, bus.ref_err};
  endfunction

  function automatic logic [22:0] mk(input logic [3:0] cmd, input logic [12:0] addr,
                                     input logic own, input logic done,
                                     input logic req, input logic err);
    return {cmd, addr, 2'b00, own, done, req, err};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic release_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = -1;
  endtask

  task automatic test_reset();
    logic [22:0] got;
    reset_n = 1'b0;
    bus.ref_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = obs();
    n_checks++;
    if (got !== mk(CMD_INHIBIT, 13'd0, 1'b1, 1'b0, 1'b0, 1'b0))
      $display("[TB] FAIL reset_state: got %h expected %h", got,
               mk(CMD_INHIBIT, 13'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    else n_pass++;
    bus.ref_ack = 1'b0;
  endtask

  task automatic test_param();
    int c;
    int found;
    logic [3:0] cmd10;
    logic [3:0] cmd16;
    c = -1;
    found = -1;
    cmd10 = 4'hx;
    cmd16 = 4'hx;
    reset2_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset2_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      c++;
      if (c == 10) cmd10 = {bus2.cs_n, bus2.ras_n, bus2.cas_n, bus2.we_n};
      if (c == 16) cmd16 = {bus2.cs_n, bus2.ras_n, bus2.cas_n, bus2.we_n};
      if (bus2.init_done && found < 0) found = c;
    end
    n_checks++;
    if (found != SMALL_DONE)
      $display("[TB] FAIL small_init_done_cycle: got %0d expected %0d", found, SMALL_DONE);
    else n_pass++;
    n_checks++;
    if (cmd10 !== CMD_PRE)
      $display("[TB] FAIL small_pre_cycle10: got %b expected %b", cmd10, CMD_PRE);
    else n_pass++;
    n_checks++;
    if (cmd16 !== CMD_MRS)
      $display("[TB] FAIL small_mrs_cycle16: got %b expected %b", cmd16, CMD_MRS);
    else n_pass++;
  endtask

  task automatic test_init(input int stop);
    logic [22:0] got;
    logic [22:0] exp;
    release_reset();
    while (cyc < stop) begin
      next_cycle();
      exp = mk(CMD_NOP, 13'd0, (cyc < 5016), (cyc >= 5016), 1'b0, 1'b0);
      if (cyc == 5000) exp = mk(CMD_PRE, 13'h0400, 1'b1, 1'b0, 1'b0, 1'b0);
      if (cyc == 5003 || cyc == 5008) exp = mk(CMD_REF, 13'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (cyc == 5013) exp = mk(CMD_MRS, 13'h0033, 1'b1, 1'b0, 1'b0, 1'b0);
      got = obs();
      n_checks++;
      if (got !== exp)
        $display("[TB] FAIL init_seq cycle %0d: got %h expected %h", cyc, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_refresh();
    logic [22:0] got;
    logic [22:0] exp;
    bus.ref_ack = 1'b1;
    while (cyc < 5794) next_cycle();
    repeat (14) begin
      next_cycle();
      exp = mk(CMD_NOP, 13'd0, (cyc >= 5798 && cyc <= 5805), 1'b1,
               (cyc == 5796 || cyc == 5797), 1'b0);
      if (cyc == 5798) exp = mk(CMD_PRE, 13'h0400, 1'b1, 1'b1, 1'b0, 1'b0);
      if (cyc == 5801) exp = mk(CMD_REF, 13'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      got = obs();
      n_checks++;
      if (got !== exp)
        $display("[TB] FAIL refresh_seq cycle %0d: got %h expected %h", cyc, got, exp);
      else n_pass++;
      if (cyc == 5806) bus.ref_ack = 1'b0;
    end
  endtask

  task automatic test_ack_ignored();
    logic [22:0] got;
    while (cyc < 5810) next_cycle();
    bus.ref_ack = 1'b1;
    next_cycle();
    bus.ref_ack = 1'b0;
    repeat (5) begin
      got = obs();
      n_checks++;
      if (got !== mk(CMD_NOP, 13'd0, 1'b0, 1'b1, 1'b0, 1'b0))
        $display("[TB] FAIL stray_ack cycle %0d: got %h expected %h", cyc, got,
                 mk(CMD_NOP, 13'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_backlog();
    logic [22:0] got;
    while (cyc < 6575) next_cycle();
    got = obs();
    n_checks++;
    if (got !== mk(CMD_NOP, 13'd0, 1'b0, 1'b1, 1'b0, 1'b0))
      $display("[TB] FAIL pre_deadline2: got %h expected %h", got,
               mk(CMD_NOP, 13'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    else n_pass++;
    next_cycle();
    got = obs();
    n_checks++;
    if (got !== mk(CMD_NOP, 13'd0, 1'b0, 1'b1, 1'b1, 1'b0))
      $display("[TB] FAIL deadline2_req: got %h expected %h", got,
               mk(CMD_NOP, 13'd0, 1'b0, 1'b1, 1'b1, 1'b0));
    else n_pass++;
    while (cyc < 8914) next_cycle();
    got = obs();
    n_checks++;
    if (got !== mk(CMD_NOP, 13'd0, 1'b0, 1'b1, 1'b1, 1'b0))
      $display("[TB] FAIL backlog3_no_err: got %h expected %h", got,
               mk(CMD_NOP, 13'd0, 1'b0, 1'b1, 1'b1, 1'b0));
    else n_pass++;
    repeat (2) next_cycle();
    got = obs();
    n_checks++;
    if (got !== mk(CMD_NOP, 13'd0, 1'b0, 1'b1, 1'b1, 1'b1))
      $display("[TB] FAIL overflow_err: got %h expected %h", got,
               mk(CMD_NOP, 13'd0, 1'b0, 1'b1, 1'b1, 1'b1));
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      bus.ref_ack = 1'b1;
      next_cycle();
      bus.ref_ack = 1'b0;
      got = obs();
      n_checks++;
      if (got !== mk(CMD_NOP, 13'd0, 1'b0, 1'b1, 1'b1, 1'b1))
        $display("[TB] FAIL drain%0d_ack_cycle: got %h expected %h", i, got,
                 mk(CMD_NOP, 13'd0, 1'b0, 1'b1, 1'b1, 1'b1));
      else n_pass++;
      next_cycle();
      got = obs();
      n_checks++;
      if (got !== mk(CMD_PRE, 13'h0400, 1'b1, 1'b1, 1'b0, 1'b1))
        $display("[TB] FAIL drain%0d_pre: got %h expected %h", i, got,
                 mk(CMD_PRE, 13'h0400, 1'b1, 1'b1, 1'b0, 1'b1));
      else n_pass++;
      repeat (3) next_cycle();
      got = obs();
      n_checks++;
      if (got !== mk(CMD_REF, 13'd0, 1'b1, 1'b1, 1'b0, 1'b1))
        $display("[TB] FAIL drain%0d_ref: got %h expected %h", i, got,
                 mk(CMD_REF, 13'd0, 1'b1, 1'b1, 1'b0, 1'b1));
      else n_pass++;
      repeat (5) next_cycle();
      got = obs();
      n_checks++;
      if (got !== mk(CMD_NOP, 13'd0, 1'b0, 1'b1, (i < 2), 1'b1))
        $display("[TB] FAIL drain%0d_idle: got %h expected %h", i, got,
                 mk(CMD_NOP, 13'd0, 1'b0, 1'b1, (i < 2), 1'b1));
      else n_pass++;
    end
  endtask

  task automatic test_mid_init_reset();
    logic [22:0] got;
    test_init(5005);
    reset_n = 1'b0;
    next_cycle();
    got = obs();
    n_checks++;
    if (got !== mk(CMD_INHIBIT, 13'd0, 1'b1, 1'b0, 1'b0, 1'b0))
      $display("[TB] FAIL mid_init_reset: got %h expected %h", got,
               mk(CMD_INHIBIT, 13'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    else n_pass++;
    test_init(5019);
  endtask

  task automatic test_mid_refresh_reset();
    logic [22:0] got;
    test_init(5019);
    bus.ref_ack = 1'b1;
    while (cyc < 5797) next_cycle();
    next_cycle();
    got = obs();
    n_checks++;
    if (got !== mk(CMD_PRE, 13'h0400, 1'b1, 1'b1, 1'b0, 1'b0))
      $display("[TB] FAIL mid_ref_pre: got %h expected %h", got,
               mk(CMD_PRE, 13'h0400, 1'b1, 1'b1, 1'b0, 1'b0));
    else n_pass++;
    next_cycle();
    reset_n = 1'b0;
    bus.ref_ack = 1'b0;
    next_cycle();
    got = obs();
    n_checks++;
    if (got !== mk(CMD_INHIBIT, 13'd0, 1'b1, 1'b0, 1'b0, 1'b0))
      $display("[TB] FAIL mid_ref_reset: got %h expected %h", got,
               mk(CMD_INHIBIT, 13'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    else n_pass++;
    test_init(5019);
  endtask

  initial begin
    bus.ref_ack = 1'b0;
    bus2.ref_ack = 1'b0;
    reset_n = 1'b0;
    reset2_n = 1'b0;
    cyc = 0;
    test_reset();
    test_param();
    test_init(5019);
    test_refresh();
    test_ack_ignored();
    test_backlog();
    test_mid_init_reset();
    test_mid_refresh_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
